// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage of the CtrlPIM controller: sequences program start, fetches
// 16-bit instructions, decodes the opcode one-hot and emits start/advance pulses.
module instr_fetch_decode #(
    parameter int ADDR_W = 8,
    parameter int OPND_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    input  logic              exec_done,
    output logic [15:0]       D,
    output logic [OPND_W-1:0] operand,
    output logic              start_load,
    output logic              next_instr,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_EXEC,
        S_ADV,
        S_HALTED
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       ir_reg, ir_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [15:0]       instr_count_reg, instr_count_next;

    logic [3:0]  opcode;
    logic        is_halt;
    logic        is_ctrl;
    logic [15:0] count_inc;

    assign opcode    = ir_reg[15:12];
    assign is_halt   = (opcode == 4'hF);
    // Opcodes 8..13 are resolved by the address select during the single EXEC cycle.
    assign is_ctrl   = (opcode >= 4'd8) && (opcode <= 4'd13);
    assign count_inc = (instr_count_reg == 16'hFFFF) ? instr_count_reg
                                                     : instr_count_reg + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            ir_reg          <= '0;
            addr_reg        <= '0;
            instr_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            ir_reg          <= ir_next;
            addr_reg        <= addr_next;
            instr_count_reg <= instr_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ir_next          = ir_reg;
        addr_next        = addr_reg;
        instr_count_next = instr_count_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                instr_count_next = '0;
                state_next       = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) begin
                    ir_next    = imem_rdata;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_halt) begin
                    state_next = S_HALTED;
                end else if (is_ctrl) begin
                    instr_count_next = count_inc;
                    state_next       = S_FETCH;
                end else if (exec_done) begin
                    state_next = S_ADV;
                end
            end
            S_ADV: begin
                instr_count_next = count_inc;
                state_next       = S_FETCH;
            end
            S_HALTED: begin
                if (start) state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
        // Freeze the fetch address for the whole request by sampling only on FETCH entry.
        if ((state_next == S_FETCH) && (state_reg != S_FETCH)) begin
            addr_next = pc_addr;
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_decode
            assign D[gi] = (state_reg == S_EXEC) && (opcode == 4'(gi));
        end
    endgenerate

    assign imem_req    = (state_reg == S_FETCH);
    assign imem_addr   = addr_reg;
    assign operand     = ir_reg[OPND_W-1:0];
    assign start_load  = (state_reg == S_LOAD);
    assign next_instr  = (state_reg == S_ADV);
    assign busy        = (state_reg != S_IDLE) && (state_reg != S_HALTED);
    assign halted      = (state_reg == S_HALTED);
    assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: vector table, hand-written corner
// sequences and a randomized program run against a per-instruction reference model.
module tb_instr_fetch_decode;

    localparam logic [7:0] START_ADDR = 8'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  pc_addr = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_valid = 1'b0;
    logic        exec_done = 1'b0;
    logic [15:0] D;
    logic [11:0] operand;
    logic        start_load;
    logic        next_instr;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_pc = 8'h00;
    logic [15:0] exp_cnt = 16'h0000;

    typedef struct {
        logic [15:0] word;
        int          waits;
        int          lat;
        logic [15:0] exp_d;
        logic [11:0] exp_opnd;
        bit          noise;
    } vec_t;

    vec_t vecs[9];

    instr_fetch_decode #(.ADDR_W(8), .OPND_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pc_addr    (pc_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .exec_done  (exec_done),
        .D          (D),
        .operand    (operand),
        .start_load (start_load),
        .next_instr (next_instr),
        .busy       (busy),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Address register of the surrounding controller: start address, +1, or jump target.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n)                 pc_addr <= 8'h00;
        else if (start_load)        pc_addr <= START_ADDR;
        else if (next_instr)        pc_addr <= pc_addr + 8'd1;
        else if (|D[13:8])          pc_addr <= operand[7:0];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_D"}, D, 0);
        chk({tag, "_operand"}, operand, 0);
        chk({tag, "_pulses"}, {start_load, next_instr}, 0);
        chk({tag, "_busy_halted"}, {busy, halted}, 0);
        chk({tag, "_count"}, instr_count, 0);
    endtask

    // Called at a negedge with the DUT in IDLE or HALTED; returns in the first FETCH cycle.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_load_c1", start_load, 1);
        chk("busy_c1", busy, 1);
        chk("req_c1", imem_req, 0);
        @(negedge clk);
        chk("start_load_c2", start_load, 0);
        chk("req_c2", imem_req, 1);
        chk("count_clear", instr_count, 0);
        exp_pc  = START_ADDR;
        exp_cnt = 16'h0000;
        $display("start: load pulse seen, fetch from %h", imem_addr);
    endtask

    // Called in the first FETCH cycle; returns in the next FETCH cycle (or HALTED).
    task automatic run_instr(input logic [15:0] word, input int waits, input int lat,
                             input logic [15:0] exp_d, input logic [11:0] exp_opnd,
                             input bit noise);
        logic [3:0] op;
        op = word[15:12];
        for (int i = 0; i <= waits; i++) begin
            chk("fetch_req", imem_req, 1);
            chk("fetch_addr", imem_addr, exp_pc);
            chk("fetch_D", D, 0);
            chk("fetch_pulses", {start_load, next_instr}, 0);
            imem_valid = (i == waits);
            imem_rdata = (i == waits) ? word : 16'($urandom);
            start      = noise;
            @(negedge clk);
        end
        imem_valid = 1'b0;
        start      = 1'b0;
        imem_rdata = 16'($urandom);
        chk("exec_D", D, exp_d);
        chk("exec_operand", operand, exp_opnd);
        chk("exec_req", imem_req, 0);
        chk("exec_pulses", {start_load, next_instr}, 0);
        if (op == 4'hF) begin
            exec_done = noise;
            @(negedge clk);
            exec_done = 1'b0;
            chk("halt_halted", halted, 1);
            chk("halt_busy", busy, 0);
            chk("halt_D", D, 0);
            chk("halt_count", instr_count, exp_cnt);
        end else if (op >= 4'd8 && op <= 4'd13) begin
            exec_done = 1'b1;
            start     = noise;
            @(negedge clk);
            exec_done = 1'b0;
            start     = 1'b0;
            exp_cnt   = sat_inc(exp_cnt);
            exp_pc    = word[7:0];
            chk("jump_no_next", next_instr, 0);
            chk("jump_D_clear", D, 0);
            chk("jump_count", instr_count, exp_cnt);
        end else begin
            for (int j = 0; j < lat; j++) begin
                imem_valid = noise;
                imem_rdata = 16'($urandom);
                start      = noise;
                @(negedge clk);
                chk("exec_hold_D", D, exp_d);
                chk("exec_hold_next", next_instr, 0);
            end
            imem_valid = 1'b0;
            start      = 1'b0;
            exec_done  = 1'b1;
            @(negedge clk);
            exec_done = 1'b0;
            chk("adv_next", next_instr, 1);
            chk("adv_D", D, 0);
            chk("adv_start_load", start_load, 0);
            chk("adv_count_old", instr_count, exp_cnt);
            start = noise;
            @(negedge clk);
            start   = 1'b0;
            exp_cnt = sat_inc(exp_cnt);
            exp_pc  = exp_pc + 8'd1;
            chk("after_adv_next", next_instr, 0);
            chk("after_adv_count", instr_count, exp_cnt);
        end
        $display("instr word=%h waits=%0d lat=%0d noise=%0d count=%h", word, waits, lat, noise, instr_count);
    endtask

    initial begin
        vecs[0] = '{16'h2005, 0, 1, 16'h0004, 12'h005, 1'b0};
        vecs[1] = '{16'hA010, 0, 0, 16'h0400, 12'h010, 1'b1};
        vecs[2] = '{16'h1234, 3, 2, 16'h0002, 12'h234, 1'b1};
        vecs[3] = '{16'h8040, 1, 0, 16'h0100, 12'h040, 1'b0};
        vecs[4] = '{16'hE0FF, 2, 3, 16'h4000, 12'h0FF, 1'b1};
        vecs[5] = '{16'hD020, 0, 0, 16'h2000, 12'h020, 1'b1};
        vecs[6] = '{16'h7003, 1, 0, 16'h0080, 12'h003, 1'b0};
        vecs[7] = '{16'h0000, 0, 2, 16'h0001, 12'h000, 1'b1};
        vecs[8] = '{16'hF000, 3, 0, 16'h8000, 12'h000, 1'b1};

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        imem_valid = 1'b1;
        imem_rdata = 16'hF123;
        @(negedge clk);
        imem_valid = 1'b0;
        chk("idle_valid_busy", busy, 0);
        chk("idle_valid_operand", operand, 0);

        // Table-driven program ending in HALT
        do_start();
        for (int k = 0; k < 9; k++) begin
            run_instr(vecs[k].word, vecs[k].waits, vecs[k].lat,
                      vecs[k].exp_d, vecs[k].exp_opnd, vecs[k].noise);
        end

        // Memory responses while halted are ignored; restart clears the count
        imem_valid = 1'b1;
        imem_rdata = 16'h2ABC;
        @(negedge clk);
        imem_valid = 1'b0;
        chk("halted_valid_operand", operand, 12'h000);
        chk("halted_valid_state", halted, 1);
        do_start();

        // Reset during the FETCH wait, then a late imem_valid
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_fetch");
        imem_valid = 1'b1;
        imem_rdata = 16'h3001;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        chk("late_valid_busy", busy, 0);
        chk("late_valid_D", D, 0);
        chk("late_valid_operand", operand, 0);
        do_start();
        run_instr(16'h3007, 1, 0, 16'h0008, 12'h007, 1'b0);

        // Reset during EXEC
        imem_valid = 1'b1;
        imem_rdata = 16'h4ABC;
        @(negedge clk);
        imem_valid = 1'b0;
        chk("pre_rst_exec_D", D, 16'h0010);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_exec");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        run_instr(16'h9033, 0, 0, 16'h0200, 12'h033, 1'b1);

        // Counter saturation: preload near the top instead of retiring 65k instructions
        force dut.instr_count_reg = 16'hFFFD;
        @(negedge clk);
        release dut.instr_count_reg;
        exp_cnt = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            run_instr(16'h0000, 0, 0, 16'h0001, 12'h000, 1'b1);
        end
        run_instr(16'hB044, 1, 0, 16'h0800, 12'h044, 1'b1);
        chk("sat_hold", instr_count, 16'hFFFF);
        run_instr(16'hF555, 0, 0, 16'h8000, 12'h555, 1'b0);

        // Randomized program against the per-instruction model
        do_start();
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  rop;
            logic [15:0] rword;
            rop   = 4'($urandom_range(0, 15));
            rword = {rop, 12'($urandom)};
            run_instr(rword, $urandom_range(0, 3), $urandom_range(0, 3),
                      16'(16'd1 << rop), rword[11:0], 1'($urandom_range(0, 1)));
            if (rop == 4'hF) do_start();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Fetch/decode stage of the CtrlPIM controller, directly upstream of the address-select logic. It sequences program start, fetches 16-bit instructions from instruction memory at the current program address, and decodes the 4-bit opcode into the one-hot vector `D`. It also generates the `start_load` and `next_instr` pulses that, together with `D` and `eqz`, choose the next program address. It waits on the datapath for multi-cycle instructions and stops on HALT.

## Interface
Parameters:
- `ADDR_W`, 8, width of the program address
- `OPND_W`, 12, operand field width (instruction bits [11:0])

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle request to run the program from its start address
- `pc_addr`  in  ADDR_W  current program address from the address register
- `imem_req`  out  1  fetch request; held until `imem_valid`
- `imem_addr`  out  ADDR_W  fetch address; equals `pc_addr` sampled on FETCH entry, stable while `imem_req`=1
- `imem_rdata`  in  16  instruction word; valid when `imem_valid`=1
- `imem_valid`  in  1  memory response; ignored outside FETCH
- `exec_done`  in  1  datapath completion of the current non-control instruction
- `D`  out  16  one-hot decoded opcode; `D[k]`=1 iff IR[15:12]==k and state==EXEC; otherwise 0
- `operand`  out  OPND_W  IR[11:0]; holds its value between instructions
- `start_load`  out  1  one-cycle pulse that selects the start address
- `next_instr`  out  1  one-cycle pulse that advances to the next address
- `busy`  out  1  high in every state except IDLE and HALTED
- `halted`  out  1  high in HALTED
- `instr_count`  out  16  count of retired instructions; saturates at 16'hFFFF

## Operation
- States: IDLE, LOAD, FETCH, EXEC, ADV, HALTED. All outputs are Moore, decoded from registered state and IR.
- IDLE: if `start`=1, go to LOAD.
- LOAD: `start_load`=1 for this one cycle. Clear `instr_count`. Go to FETCH.
- FETCH: `imem_req`=1 and `imem_addr` is frozen. When `imem_valid`=1, IR <= `imem_rdata` and go to EXEC. Otherwise stay.
- EXEC: `D` = onehot(IR[15:12]).
  - Opcode 15 (HALT): go to HALTED.
  - Opcodes 8–13 (control flow): the address select acts on `D`/`eqz` during this cycle. Increment `instr_count` and go to FETCH. No `next_instr` pulse.
  - All other opcodes: stay in EXEC until `exec_done`=1, then go to ADV.
- ADV: `next_instr`=1 for one cycle with `D`=0. Increment `instr_count`. Go to FETCH.
- HALTED: `halted`=1. `start`=1 goes to LOAD (restart). HALT itself is not counted in `instr_count`.
- `start` is ignored in LOAD, FETCH, EXEC and ADV.
- `exec_done` is ignored outside EXEC, and in EXEC when a control-flow or HALT opcode is present.
- `start_load` and `next_instr` are never high in the same cycle. `D` is never nonzero while either pulse is high.

## Timing
- Reset values (asynchronous, on `rst_n`=0): state=IDLE, IR=0, `operand`=0, `D`=0, `imem_req`=0, `imem_addr`=0, `start_load`=0, `next_instr`=0, `busy`=0, `halted`=0, `instr_count`=0.
- Reset mid-fetch drops `imem_req` immediately. A late `imem_valid` is then ignored.
- Timing with `start` in cycle 0 and zero-wait memory:
  - `start_load` is high in cycle 1.
  - `imem_req` is high in cycle 2, with `imem_addr` = `pc_addr` as seen at the cycle-2 edge (already the start address).
  - `D` is valid in cycle 3.
- Control-flow instruction: the next FETCH is the cycle after EXEC, so each jump costs 1 cycle plus the memory wait.
- Other opcodes: ADV follows EXEC by one cycle after `exec_done`. `exec_done` arriving in the first EXEC cycle gives EXEC=1 cycle, then ADV.
- Memory wait states: `imem_req` stays high and `imem_addr` stays stable for the full wait. `imem_rdata` is captured only in the `imem_valid` cycle.
- `instr_count` updates on the edge leaving EXEC (control flow) or leaving ADV. At 16'hFFFF it holds.

## Test plan
- Reset, then `start` at cycle 0 with zero-wait memory returning 16'h2005 → `start_load` high in cycle 1 only; `imem_req` in cycle 2; in cycle 3 `D`=16'h0004 and `operand`=12'h005; `exec_done` at cycle 4 → `next_instr` high in cycle 5; `instr_count`=1.
- Fetch 16'hA010 (opcode 10) → `D`=16'h0400 for exactly one cycle, no `next_instr`, then FETCH; `exec_done` pulses during that EXEC have no effect.
- Memory with 3 wait states → `imem_req` high 4 cycles, `imem_addr` constant; `imem_valid` pulses injected in IDLE/EXEC are ignored.
- Fetch 16'hF000 → `D`=16'h8000 for one cycle, then `halted`=1, `busy`=0, `instr_count` unchanged; `start` → `start_load` pulse and `instr_count`=0.
- `rst_n` asserted during the FETCH wait and during EXEC → all outputs return to reset values asynchronously; a following `start` runs normally.
- 65,540 NOP-class instructions → `instr_count` saturates at 16'hFFFF; `start` while `busy` leaves state and all pulses unaffected.
